// File: rtl/sorter_ctrl.sv
// Handshake controller wrapping a fixed-latency byte sorter: one job in flight, latency SORT_LAT.
// Optional ordering checker enabled by defining SORTER_CTRL_CHECK_EN.
module sorter_ctrl #(
  parameter int unsigned SORT_LAT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  output logic [63:0] srt_in,
  input  logic [63:0] srt_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic        busy,
  output logic [15:0] job_cnt,
  output logic        sort_err
);

  typedef enum logic [1:0] {StIdle, StWait, StHold} state_e;

  localparam logic [3:0] LatInit = 4'(SORT_LAT);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [63:0] srt_in_q, srt_in_d;
  logic [63:0] out_data_q, out_data_d;
  logic        out_valid_q, out_valid_d;
  logic [15:0] job_cnt_q, job_cnt_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    srt_in_d    = srt_in_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    job_cnt_d   = job_cnt_q;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          srt_in_d = in_data;
          cnt_d    = LatInit;
          state_d  = StWait;
        end
      end
      StWait: begin
        // Count reaches 1 on the cycle before the SORT_LAT-th edge after acceptance.
        if (cnt_q <= 4'd1) begin
          cnt_d       = 4'd0;
          out_data_d  = srt_out;
          out_valid_d = 1'b1;
          state_d     = StHold;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StHold: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          job_cnt_d   = job_cnt_q + 16'd1;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      srt_in_q    <= 64'd0;
      out_data_q  <= 64'd0;
      out_valid_q <= 1'b0;
      job_cnt_q   <= 16'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      srt_in_q    <= srt_in_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      job_cnt_q   <= job_cnt_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign srt_in    = srt_in_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign job_cnt   = job_cnt_q;

`ifdef SORTER_CTRL_CHECK_EN
  logic capture;
  logic order_bad;
  logic sort_err_q;

  assign capture = (state_q == StWait) && (cnt_q <= 4'd1);

  // Required order is ascending from the least significant byte.
  always_comb begin
    order_bad = 1'b0;
    for (int k = 0; k < 7; k++) begin
      if (srt_out[8*k +: 8] > srt_out[8*(k+1) +: 8]) order_bad = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sort_err_q <= 1'b0;
    end else if (capture && order_bad) begin
      sort_err_q <= 1'b1;
    end
  end

  assign sort_err = sort_err_q;
`else
  assign sort_err = 1'b0;
`endif

endmodule
